// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
//   Shared constants and types for the Simon game blocks.
//   - MAX_LEVEL / LEVEL_W : highest playable level and width of level/address
//   - colour_t            : colour index stored in the sequence RAM
//   - blink_state_t       : playback states of sequence_blinker
//   - timer_width()       : counter width able to hold max(a,b)-1
//   - colour_onehot()     : colour index to one-hot LED drive
// ---------------------------------------------------------------------------
package simon_pkg;

    localparam int MAX_LEVEL = 10;
    localparam int LEVEL_W   = 4;

    typedef enum logic [1:0] {
        RED,
        GREEN,
        BLUE,
        YELLOW
    } colour_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ON,
        OFF,
        DONE
    } blink_state_t;

    // Bits needed for a down-counter that starts at max(a,b)-1; never below 1.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [3:0] colour_onehot(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
//   Loadable down-counter with a zero flag. Load has priority over decrement.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous, active-low; clears the count
//     load       in   load load_value this cycle
//     load_value in   WIDTH-bit value to load
//     dec        in   decrement this cycle (ignored while load=1)
//     zero       out  count is zero (registered state only)
// ---------------------------------------------------------------------------
module tick_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sequence_blinker.sv
// ---------------------------------------------------------------------------
// sequence_blinker
//   Simon playback engine. On the game FSM's on_blinker request it reads the
//   stored colour sequence (entries 0..level-1) from the sequence RAM and
//   flashes one LED per entry: ON_CYCLES lit, then OFF_CYCLES dark. After the
//   last entry it raises blinker_done until on_blinker drops.
//   Ports:
//     clk           in   clock, rising edge
//     reset         in   synchronous, active-low
//     on_blinker    in   start/hold request, held for the whole playback
//     level         in   entries to play, sampled at start, clamped to MAX_LEVEL
//     mem_addr      out  sequence RAM read address
//     mem_rd        out  sequence RAM read strobe
//     mem_data      in   colour index, valid one cycle after mem_rd
//     leds          out  one-hot LED drive, 0 = dark
//     blinker_done  out  playback complete
//   All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module sequence_blinker #(
    parameter int unsigned ON_CYCLES  = 12_500_000,
    parameter int unsigned OFF_CYCLES = 6_250_000,
    parameter int unsigned MAX_LEVEL  = simon_pkg::MAX_LEVEL,
    parameter int unsigned LEVEL_W    = simon_pkg::LEVEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               on_blinker,
    input  logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] mem_addr,
    output logic               mem_rd,
    input  logic [1:0]         mem_data,
    output logic [3:0]         leds,
    output logic               blinker_done
);

    import simon_pkg::*;

    localparam int unsigned        TW       = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0]      ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]      OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] MAX_LVL  = LEVEL_W'(MAX_LEVEL);

    blink_state_t       state;
    blink_state_t       state_next;

    logic [LEVEL_W-1:0] idx;
    logic [LEVEL_W-1:0] lvl;
    colour_t            colour;

    logic [LEVEL_W-1:0] lvl_start;
    logic               last_entry;

    logic               timer_load;
    logic               timer_dec;
    logic [TW-1:0]      timer_value;
    logic               timer_zero;

    // Level presented at start, clamped to the highest playable level.
    assign lvl_start  = (level > MAX_LVL) ? MAX_LVL : level;

    // Only evaluated in OFF, where lvl is at least 1.
    assign last_entry = (idx == (lvl - LEVEL_W'(1)));

    // One timer serves both the lit and dark phases: WAIT arms it with the lit
    // length, and the cycle ON expires it is re-armed with the dark length.
    tick_timer #(
        .WIDTH (TW)
    ) u_tick_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx    <= '0;
            lvl    <= '0;
            colour <= RED;
        end else begin
            unique case (state)
                IDLE: begin
                    if (on_blinker) begin
                        lvl <= lvl_start;
                        idx <= '0;
                    end
                end
                WAIT: begin
                    colour <= colour_t'(mem_data);
                end
                OFF: begin
                    if (on_blinker && timer_zero && !last_entry) begin
                        idx <= idx + LEVEL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (on_blinker) begin
                    state_next = (lvl_start == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_next = on_blinker ? WAIT : IDLE;
            end
            WAIT: begin
                state_next = on_blinker ? ON : IDLE;
            end
            ON: begin
                if (!on_blinker) begin
                    state_next = IDLE;
                end else if (timer_zero) begin
                    state_next = OFF;
                end
            end
            OFF: begin
                if (!on_blinker) begin
                    state_next = IDLE;
                end else if (timer_zero) begin
                    state_next = last_entry ? DONE : FETCH;
                end
            end
            DONE: begin
                if (!on_blinker) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- timer control
    always_comb begin
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = ON_LOAD;
        unique case (state)
            WAIT: begin
                timer_load  = 1'b1;
                timer_value = ON_LOAD;
            end
            ON: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = OFF_LOAD;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            OFF: begin
                timer_dec = !timer_zero;
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        leds         = '0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        blinker_done = 1'b0;
        unique case (state)
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = idx;
            end
            ON: begin
                leds = colour_onehot(colour);
            end
            DONE: begin
                blinker_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
